// File: rtl/uart_tx_if.sv
// Write-side bus of uart_tx: the core pushes bytes and observes ready/occupancy.
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic [CW-1:0] fifo_count;

  modport master (output wr_valid, wr_data, input wr_ready, fifo_count);
  modport slave  (input wr_valid, wr_data, output wr_ready, fifo_count);
endinterface

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter with a FIFO_DEPTH-entry transmit FIFO, LSB first, no idle gap
// between queued bytes. 8N1 by default; define UART_TX_PARITY_EN for 8E1 frames.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic     clk,
  input  logic     resetn,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     tx_busy
);
  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = PW + 1;
  localparam int            TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          push, pop;
  logic [7:0]    head;

  assign bus.wr_ready   = (count_q != CW'(FIFO_DEPTH));
  assign bus.fifo_count = count_q;
  assign push           = bus.wr_valid && bus.wr_ready;
  assign head           = mem[rd_ptr];

  // NOTE: the storage array has no reset; entries are only read where count_q marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // ---------------- framing FSM ----------------
  state_t        state_q, state_d;
  logic          tx_q, tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_frame;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // A new frame starts from IDLE, or straight out of a finished STOP bit when more bytes wait.
  assign start_frame = (count_q != '0) &&
                       ((state_q == IDLE) || ((state_q == STOP) && (timer_q == '0)));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (timer_q != '0) timer_d = timer_q - TW'(1);

    case (state_q)
      IDLE: ;
      START: begin
        if (timer_q == '0) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          timer_d = BIT_LOAD;
          state_d = DATA;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = BIT_LOAD;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (timer_q == '0) begin
          tx_d    = 1'b1;
          timer_d = BIT_LOAD;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if ((timer_q == '0) && (count_q == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      shift_d = head;
      tx_d    = 1'b0;
      timer_d = BIT_LOAD;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven burst vectors, hand-written corner sequences,
// and random traffic compared cycle by cycle against a waveform-level reference model.
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic tx, tx_busy;

  uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .tx     (tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: queued bytes plus the line level expected after each future edge.
  logic [7:0] m_fifo[$];
  bit         m_wave[$];
  bit         m_tx   = 1'b1;
  bit         m_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && FRAME_BITS == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_wave.delete();
    m_tx   = 1'b1;
    m_busy = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d);
    bit ready;
    bit from_frame;
    logic [7:0] b;
    ready      = (m_fifo.size() != DEPTH);
    from_frame = 1'b0;
    if (m_wave.size() == 0 && m_fifo.size() != 0) begin
      b = m_fifo.pop_front();
      for (int k = 0; k < FRAME_BITS; k++)
        for (int r = 0; r < CPB; r++) m_wave.push_back(frame_bit(b, k));
    end
    if (m_wave.size() != 0) begin
      m_tx       = m_wave.pop_front();
      from_frame = 1'b1;
    end else begin
      m_tx = 1'b1;
    end
    if (v && ready) m_fifo.push_back(d);
    m_busy = from_frame || (m_fifo.size() != 0);
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk);
    bus.wr_valid = v;
    bus.wr_data  = d;
    check($sformatf("ready_pre@%0d", cyc), bus.wr_ready, m_fifo.size() != DEPTH);
    model_edge(v, d);
    @(posedge clk);
    #1;
    cyc++;
    check($sformatf("tx@%0d", cyc), tx, m_tx);
    check($sformatf("count@%0d", cyc), bus.fifo_count, m_fifo.size());
    check($sformatf("ready@%0d", cyc), bus.wr_ready, m_fifo.size() != DEPTH);
    check($sformatf("busy@%0d", cyc), tx_busy, m_busy);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (m_fifo.size() == 0 && m_wave.size() == 0 && !m_busy) break;
      step(1'b0, 8'h00);
    end
    check("drain_busy", tx_busy, 1'b0);
  endtask

  typedef struct {
    bit         valid;
    logic [7:0] data;
    int         exp_count;
    bit         exp_ready;
    bit         exp_tx;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    int prob;

    // Burst of 0x01..0x06 on consecutive cycles from idle; 0x06 finds the FIFO full.
    tbl[0] = '{1'b1, 8'h01, 1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 8'h02, 1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 3, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 4, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h06, 4, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 4, 1'b0, 1'b1};

    resetn       = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    #2 resetn = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", bus.wr_ready, 1'b1);
    check("rst_count", bus.fifo_count, 0);
    check("rst_busy", tx_busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("rst_tx_held", tx, 1'b1);
    @(negedge clk) resetn = 1'b1;
    model_reset();

    // Idle for 100 cycles after reset release.
    repeat (100) step(1'b0, 8'h00);

    // Single 0x55 frame; busy must stay high for one full frame after the pop.
    step(1'b1, 8'h55);
    check("w55_count_e0", bus.fifo_count, 1);
    check("w55_tx_e0", tx, 1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 8'h00);
      if (tx_busy) n++;
      else break;
    end
    check("w55_busy_cycles", n, FRAME_BITS * CPB);
    drain();

    // Table-driven burst.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].valid, tbl[i].data);
      check($sformatf("tbl%0d_count", i), bus.fifo_count, tbl[i].exp_count);
      check($sformatf("tbl%0d_ready", i), bus.wr_ready, tbl[i].exp_ready);
      check($sformatf("tbl%0d_tx", i), tx, tbl[i].exp_tx);
    end

    // Write held on the stop-end pop edge while full: refused there, taken one edge later.
    repeat (FRAME_BITS * CPB - 6) step(1'b0, 8'h00);
    step(1'b1, 8'h77);
    check("full_pop_edge_count", bus.fifo_count, 3);
    check("full_pop_edge_tx", tx, 1'b0);
    step(1'b1, 8'h77);
    check("full_next_edge_count", bus.fifo_count, 4);
    check("full_next_edge_ready", bus.wr_ready, 1'b0);
    step(1'b0, 8'h00);
    drain();

`ifdef UART_TX_PARITY_EN
    step(1'b1, 8'h07);
    repeat (37) step(1'b0, 8'h00);
    check("parity_07", tx, 1'b1);
    drain();
    step(1'b1, 8'h03);
    repeat (37) step(1'b0, 8'h00);
    check("parity_03", tx, 1'b0);
    drain();
`endif

    // Reset in the middle of a 0xFF data phase with another byte queued.
    step(1'b1, 8'hFF);
    step(1'b1, 8'h12);
    repeat (8) step(1'b0, 8'h00);
    #2 resetn = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_count", bus.fifo_count, 0);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_ready", bus.wr_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 check("midrst_tx_held", tx, 1'b1);
    @(negedge clk) resetn = 1'b1;
    model_reset();
    step(1'b1, 8'hA3);
    drain();

    // Random traffic in phases of differing write density.
    for (int p = 0; p < 15; p++) begin
      prob = (p % 3 == 0) ? 5 : ((p % 3 == 1) ? 30 : 90);
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < prob, 8'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
